pc_flow_ctrl: RTL and testbench

Sequential responder that drives the select and write-enable controls of the PC-source multiplexer, the PC register and the EPC register. The main control FSM issues one PC-update request per instruction. This block resolves the request into the PCSource code, conditional PCWrite and EPCWrite, and runs the multi-cycle exception-vector fetch, then signals completion. It sits between the main control unit and the PC/EPC datapath.

---
 rtl/pc_flow_ctrl.sv | 143 ++++++++++++++
 tb/tb_pc_flow_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_flow_ctrl.sv
// PC/EPC write-control sequencer: resolves one PC-update request per instruction
// and runs the exception-vector fetch. Optional cause register: `PCFLOW_CAUSE_REG_EN.
module pc_flow_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [1:0]  req_cause,
  input  logic        zero,
  input  logic        gt,
  output logic        req_ready,
  output logic        done,
  output logic [3:0]  PCSource,
  output logic        PCWrite,
  output logic        EPCWrite,
  output logic        alu_pcm4,
  output logic        exc_addr_sel,
  output logic        mem_read,
`ifdef PCFLOW_CAUSE_REG_EN
  output logic [1:0]  cause_q,
`endif
  output logic [31:0] exc_addr
);

  typedef enum logic [2:0] {
    IDLE,
    COMMIT,
    EXC_SAVE,
    EXC_READ,
    EXC_LOAD
  } state_t;

  localparam logic [3:0] OP_SEQ = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BNE = 4'd2;
  localparam logic [3:0] OP_BLE = 4'd3;
  localparam logic [3:0] OP_BGT = 4'd4;
  localparam logic [3:0] OP_J   = 4'd5;
  localparam logic [3:0] OP_JR  = 4'd6;
  localparam logic [3:0] OP_RTE = 4'd7;
  localparam logic [3:0] OP_EXC = 4'd8;

  localparam logic [3:0] SRC_ALU_RESULT = 4'd0;
  localparam logic [3:0] SRC_ALUOUT     = 4'd1;
  localparam logic [3:0] SRC_SHIFT_28   = 4'd2;
  localparam logic [3:0] SRC_EPC_OUT    = 4'd3;
  localparam logic [3:0] SRC_SIGN_8_32  = 4'd4;

  localparam logic [1:0] READ_CNT_INIT = 2'(MEM_LAT - 1);

  state_t     state_reg;
  logic [1:0] cause_reg;
  logic [1:0] cnt_reg;

  assign req_ready = (state_reg == IDLE);

  // COMMIT outputs are resolved at acceptance, so the flags are sampled exactly once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cause_reg    <= 2'd0;
      cnt_reg      <= 2'd0;
      done         <= 1'b0;
      PCSource     <= SRC_ALU_RESULT;
      PCWrite      <= 1'b0;
      EPCWrite     <= 1'b0;
      alu_pcm4     <= 1'b0;
      exc_addr_sel <= 1'b0;
      mem_read     <= 1'b0;
      exc_addr     <= 32'd0;
`ifdef PCFLOW_CAUSE_REG_EN
      cause_q      <= 2'd0;
`endif
    end else begin
      done         <= 1'b0;
      PCSource     <= SRC_ALU_RESULT;
      PCWrite      <= 1'b0;
      EPCWrite     <= 1'b0;
      alu_pcm4     <= 1'b0;
      exc_addr_sel <= 1'b0;
      mem_read     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            if (req_op <= OP_RTE) begin
              state_reg <= COMMIT;
              done      <= 1'b1;
              case (req_op)
                OP_BEQ: begin PCSource <= SRC_ALUOUT; PCWrite <= zero;  end
                OP_BNE: begin PCSource <= SRC_ALUOUT; PCWrite <= !zero; end
                OP_BLE: begin PCSource <= SRC_ALUOUT; PCWrite <= !gt;   end
                OP_BGT: begin PCSource <= SRC_ALUOUT; PCWrite <= gt;    end
                OP_J:   begin PCSource <= SRC_SHIFT_28; PCWrite <= 1'b1; end
                OP_RTE: begin PCSource <= SRC_EPC_OUT;  PCWrite <= 1'b1; end
                default: begin PCSource <= SRC_ALU_RESULT; PCWrite <= 1'b1; end
              endcase
            end else begin
              // Illegal opcodes and cause 3 both map to the invalid-opcode vector.
              state_reg <= EXC_SAVE;
              EPCWrite  <= 1'b1;
              alu_pcm4  <= 1'b1;
              cause_reg <= (req_op == OP_EXC && req_cause != 2'd3) ? req_cause : 2'd0;
            end
          end
        end
        COMMIT: begin
          state_reg <= IDLE;
        end
        EXC_SAVE: begin
          state_reg    <= EXC_READ;
          cnt_reg      <= READ_CNT_INIT;
          exc_addr_sel <= 1'b1;
          mem_read     <= 1'b1;
          exc_addr     <= 32'd253 + {30'd0, cause_reg};
`ifdef PCFLOW_CAUSE_REG_EN
          cause_q      <= cause_reg;
`endif
        end
        EXC_READ: begin
          if (cnt_reg == 2'd0) begin
            state_reg <= EXC_LOAD;
            PCSource  <= SRC_SIGN_8_32;
            PCWrite   <= 1'b1;
            done      <= 1'b1;
          end else begin
            cnt_reg      <= cnt_reg - 2'd1;
            exc_addr_sel <= 1'b1;
            mem_read     <= 1'b1;
          end
        end
        EXC_LOAD: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Scoreboard bench for pc_flow_ctrl (MEM_LAT=2): stimulus queues expected output
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_pc_flow_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [1:0]  req_cause;
  logic        zero;
  logic        gt;
  logic        req_ready;
  logic        done;
  logic [3:0]  PCSource;
  logic        PCWrite;
  logic        EPCWrite;
  logic        alu_pcm4;
  logic        exc_addr_sel;
  logic        mem_read;
  logic [31:0] exc_addr;
`ifdef PCFLOW_CAUSE_REG_EN
  logic [1:0]  cause_q;
`endif

  pc_flow_ctrl #(.MEM_LAT(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_op(req_op),
    .req_cause(req_cause),
    .zero(zero),
    .gt(gt),
    .req_ready(req_ready),
    .done(done),
    .PCSource(PCSource),
    .PCWrite(PCWrite),
    .EPCWrite(EPCWrite),
    .alu_pcm4(alu_pcm4),
    .exc_addr_sel(exc_addr_sel),
    .mem_read(mem_read),
`ifdef PCFLOW_CAUSE_REG_EN
    .cause_q(cause_q),
`endif
    .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          cyc;
    logic [3:0]  src;
    logic        pcw;
    logic        epcw;
    logic        pcm4;
    logic        sel;
    logic        mrd;
    logic [31:0] addr;
    logic        dn;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_act;
  ev_t         mon_exp;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_addr = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && (done | PCWrite | EPCWrite | alu_pcm4 | exc_addr_sel | mem_read)) begin
      mon_act = '{cyc: cyc, src: PCSource, pcw: PCWrite, epcw: EPCWrite, pcm4: alu_pcm4,
                  sel: exc_addr_sel, mrd: mem_read, addr: exc_addr, dn: done};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d act src=%0d pcw=%b epcw=%b pcm4=%b sel=%b mrd=%b addr=%0d done=%b, required no event",
                 cyc, PCSource, PCWrite, EPCWrite, alu_pcm4, exc_addr_sel, mem_read, exc_addr, done);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act.cyc != mon_exp.cyc) begin
          errors++;
          $display("FAIL event_cycle act=%0d required=%0d", mon_act.cyc, mon_exp.cyc);
        end
        checks++;
        if (mon_act[$bits(ev_t)-33:0] != mon_exp[$bits(ev_t)-33:0]) begin
          errors++;
          $display("FAIL event_value cyc=%0d act src=%0d pcw=%b epcw=%b pcm4=%b sel=%b mrd=%b addr=%0d done=%b, required src=%0d pcw=%b epcw=%b pcm4=%b sel=%b mrd=%b addr=%0d done=%b",
                   cyc, mon_act.src, mon_act.pcw, mon_act.epcw, mon_act.pcm4, mon_act.sel, mon_act.mrd, mon_act.addr, mon_act.dn,
                   mon_exp.src, mon_exp.pcw, mon_exp.epcw, mon_exp.pcm4, mon_exp.sel, mon_exp.mrd, mon_exp.addr, mon_exp.dn);
        end else begin
          $display("event cyc=%0d src=%0d pcw=%b epcw=%b mrd=%b addr=%0d done=%b ok",
                   cyc, mon_act.src, mon_act.pcw, mon_act.epcw, mon_act.mrd, mon_act.addr, mon_act.dn);
        end
      end
    end
  end

  function automatic void push(input int c, input logic [3:0] s, input logic pw, input logic ew,
                               input logic p4, input logic sl, input logic mr,
                               input logic [31:0] a, input logic d);
    exp_q.push_back('{cyc: c, src: s, pcw: pw, epcw: ew, pcm4: p4, sel: sl, mrd: mr, addr: a, dn: d});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h required=%0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  // Present a request once req_ready is seen, return the acceptance cycle number.
  task automatic issue(input logic [3:0] op, input logic [1:0] c, input logic z, input logic g,
                       output int acc);
    int i;
    i = 0;
    while (!req_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout act=0 required=1");
    end
    req_valid = 1'b1;
    req_op    = op;
    req_cause = c;
    zero      = z;
    gt        = g;
    @(posedge clk);
    #1;
    acc       = cyc;
    req_valid = 1'b0;
  endtask

  task automatic commit(input logic [3:0] op, input logic z, input logic g,
                        input logic [3:0] src, input logic pw);
    int acc;
    issue(op, 2'd0, z, g, acc);
    push(acc, src, pw, 1'b0, 1'b0, 1'b0, 1'b0, exp_addr, 1'b1);
  endtask

  task automatic exc(input logic [3:0] op, input logic [1:0] c, input logic [31:0] vec);
    int acc;
    issue(op, c, 1'b0, 1'b0, acc);
    push(acc, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, exp_addr, 1'b0);
    exp_addr = vec;
    for (int k = 1; k <= LAT; k++)
      push(acc + k, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, exp_addr, 1'b0);
    push(acc + 1 + LAT, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_addr, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 4'd0;
    req_cause = 2'd0;
    zero      = 1'b0;
    gt        = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", 64'({PCSource, PCWrite, EPCWrite, done, alu_pcm4, exc_addr_sel, mem_read, exc_addr}), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd1);
`ifdef PCFLOW_CAUSE_REG_EN
    check("reset_cause_q", 64'(cause_q), 64'd0);
`endif

    // SEQ: COMMIT in N+1, ready again in N+2
    commit(4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    @(negedge clk);
    check("seq_ready_busy", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("seq_ready_back", 64'(req_ready), 64'd1);

    commit(4'd1, 1'b1, 1'b0, 4'd1, 1'b1);  // BEQ taken
    commit(4'd2, 1'b1, 1'b0, 4'd1, 1'b0);  // BNE not taken
    commit(4'd2, 1'b0, 1'b0, 4'd1, 1'b1);  // BNE taken
    commit(4'd3, 1'b0, 1'b0, 4'd1, 1'b1);  // BLE taken
    commit(4'd3, 1'b0, 1'b1, 4'd1, 1'b0);  // BLE not taken
    commit(4'd4, 1'b0, 1'b0, 4'd1, 1'b0);  // BGT with gt=0 ...
    gt = 1'b1;                              // ... flag rises after acceptance
    commit(4'd4, 1'b0, 1'b1, 4'd1, 1'b1);  // BGT taken
    commit(4'd5, 1'b0, 1'b0, 4'd2, 1'b1);  // J
    commit(4'd6, 1'b0, 1'b0, 4'd0, 1'b1);  // JR
    commit(4'd7, 1'b0, 1'b0, 4'd3, 1'b1);  // RTE

    exc(4'd8, 2'd1, 32'd254);               // overflow
    repeat (LAT + 3) @(negedge clk);
`ifdef PCFLOW_CAUSE_REG_EN
    check("cause_q_overflow", 64'(cause_q), 64'd1);
`endif
    exc(4'd8, 2'd2, 32'd255);               // divide by zero
    exc(4'd8, 2'd3, 32'd253);               // cause 3 folds to 0
    exc(4'd12, 2'd2, 32'd253);              // illegal opcode
    repeat (LAT + 3) @(negedge clk);
`ifdef PCFLOW_CAUSE_REG_EN
    check("cause_q_illegal", 64'(cause_q), 64'd0);
`endif

    // Request held while busy is only taken two edges after the previous accept
    issue(4'd0, 2'd0, 1'b0, 1'b0, acc);
    push(acc, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_addr, 1'b1);
    req_valid = 1'b1;
    req_op    = 4'd5;
    @(posedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    push(acc + 2, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_addr, 1'b1);
    repeat (3) @(negedge clk);

    // Reset during EXC_READ aborts the vector load
    issue(4'd8, 2'd2, 1'b0, 1'b0, acc);
    push(acc, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, exp_addr, 1'b0);
    push(acc + 1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd255, 1'b0);
    @(posedge clk);
    #7;
    reset = 1'b1;
    #1;
    check("midreset_outputs", 64'({PCSource, PCWrite, EPCWrite, done, alu_pcm4, exc_addr_sel, mem_read, exc_addr}), 64'd0);
    exp_addr = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_ready", 64'(req_ready), 64'd1);
    repeat (LAT + 2) @(negedge clk);
    commit(4'd5, 1'b0, 1'b0, 4'd2, 1'b1);  // J after reset

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
